// File: rtl/branch_sequencer_if.sv
// branch_sequencer_if: op/flag inputs and PC/stack status outputs of the branch sequencer.
interface branch_sequencer_if #(
  parameter int ADDR_W    = 8,
  parameter int RAS_DEPTH = 4
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  logic              stall;
  logic              op_valid;
  logic [1:0]        op;
  logic [2:0]        cond;
  logic [ADDR_W-1:0] target;
  logic [3:0]        stored_flags;
  logic [ADDR_W-1:0] pc;
  logic              flush;
  logic [CW-1:0]     ras_count;
  logic              err_ovf;
  logic              err_udf;
  modport master (
    output stall, op_valid, op, cond, target, stored_flags,
    input  pc, flush, ras_count, err_ovf, err_udf
  );
  modport slave (
    input  stall, op_valid, op, cond, target, stored_flags,
    output pc, flush, ras_count, err_ovf, err_udf
  );
endinterface

// File: rtl/branch_sequencer.sv
// branch_sequencer: PC sequencing, conditional jumps, CALL/RET return stack and one-cycle flush bubble.
module branch_sequencer #(
  parameter int              ADDR_W    = 8,
  parameter int              RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic rst,
  branch_sequencer_if.slave bus
);
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam int SW = $clog2(RAS_DEPTH);
  typedef enum logic {RUN, BUBBLE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_inc;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d, udf_q, udf_d;
  logic              push, cond_ok, full, empty;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  logic [1:0]        op_eff;
  logic [7:0]        cond_tab;
  logic [SW-1:0]     top;
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign full    = cnt_q == CW'(RAS_DEPTH);
  assign empty   = cnt_q == '0;
  assign top     = SW'(cnt_q - CW'(1));
  assign op_eff  = bus.op_valid ? bus.op : 2'b00;
  // indexed by cond: 7 N, 6 !V, 5 V, 4 !C, 3 C, 2 !Z, 1 Z, 0 always
  assign cond_tab = {bus.stored_flags[3], ~bus.stored_flags[1], bus.stored_flags[1],
                     ~bus.stored_flags[2], bus.stored_flags[2], ~bus.stored_flags[0],
                     bus.stored_flags[0], 1'b1};
  assign cond_ok = cond_tab[bus.cond];
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    push    = 1'b0;
    if (!bus.stall) begin
      if (state_q == BUBBLE) state_d = RUN;
      else begin
        pc_d = pc_inc;
        case (op_eff)
          2'b01: if (cond_ok) begin
            pc_d    = bus.target;
            state_d = BUBBLE;
          end
          2'b10: begin
            pc_d    = bus.target;
            state_d = BUBBLE;
            push    = !full;
            cnt_d   = full ? cnt_q : cnt_q + CW'(1);
            ovf_d   = ovf_q | full;
          end
          2'b11: if (empty) udf_d = 1'b1;
          else begin
            pc_d    = ras_q[top];
            cnt_d   = cnt_q - CW'(1);
            state_d = BUBBLE;
          end
          default: ;
        endcase
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end
  // stack contents need no reset; occupancy alone decides what is valid
  always_ff @(posedge clk) begin
    if (push) ras_q[SW'(cnt_q)] <= pc_inc;
  end
  assign bus.pc        = pc_q;
  assign bus.flush     = state_q == BUBBLE;
  assign bus.ras_count = cnt_q;
  assign bus.err_ovf   = ovf_q;
  assign bus.err_udf   = udf_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed scenarios plus randomized run against a queue-based reference model.
module tb_branch_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  branch_sequencer_if #(.ADDR_W(8), .RAS_DEPTH(4)) bus();
  branch_sequencer #(.ADDR_W(8), .RAS_DEPTH(4), .RESET_PC(8'h00)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int total = 0;
  int bad   = 0;
  bit [7:0] mpc;
  bit [7:0] mstack[$];
  bit mbub, movf, mudf;

  function automatic bit cond_true(input bit [2:0] c, input bit [3:0] f);
    case (c)
      3'd0: return 1'b1;
      3'd1: return f[0];
      3'd2: return !f[0];
      3'd3: return f[2];
      3'd4: return !f[2];
      3'd5: return f[1];
      3'd6: return !f[1];
      default: return f[3];
    endcase
  endfunction

  task automatic model_reset();
    mpc = 8'h00;
    mstack.delete();
    mbub = 0;
    movf = 0;
    mudf = 0;
  endtask

  task automatic step(input bit s, input bit v, input bit [1:0] o, input bit [2:0] c,
                      input bit [7:0] t, input bit [3:0] f);
    bus.stall = s; bus.op_valid = v; bus.op = o; bus.cond = c; bus.target = t; bus.stored_flags = f;
    @(posedge clk);
    if (!s) begin
      if (mbub) mbub = 0;
      else case (v ? o : 2'd0)
        2'd1: if (cond_true(c, f)) begin mpc = t; mbub = 1; end else mpc++;
        2'd2: begin
          if (mstack.size() == 4) movf = 1; else mstack.push_back(mpc + 8'd1);
          mpc = t;
          mbub = 1;
        end
        2'd3: if (mstack.size() == 0) begin mudf = 1; mpc++; end
              else begin mpc = mstack.pop_back(); mbub = 1; end
        default: mpc++;
      endcase
    end
    @(negedge clk);
  endtask

  task automatic nop();
    step(0, 0, 2'd0, 3'd0, 8'h00, 4'h0);
  endtask

  task automatic go(input bit [7:0] a);
    step(0, 1, 2'd1, 3'd0, a, 4'h0);
    nop();
  endtask

  task automatic do_reset();
    bus.stall = 0; bus.op_valid = 0; bus.op = 0; bus.cond = 0; bus.target = 0; bus.stored_flags = 0;
    rst = 1;
    @(negedge clk);
    rst = 0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({bus.pc, bus.flush, bus.ras_count, bus.err_ovf, bus.err_udf} !== 14'h0) begin
      bad++; $display("FAIL reset_values got=%h exp=0", {bus.pc, bus.flush, bus.ras_count, bus.err_ovf, bus.err_udf});
    end
    step(0, 1, 2'd2, 3'd0, 8'h10, 4'h0); nop();
    step(0, 1, 2'd2, 3'd0, 8'h22, 4'h0); nop(); nop();
    total++;
    if (bus.pc !== 8'h23 || bus.ras_count !== 3'd2) begin
      bad++; $display("FAIL reset_setup got pc=%h cnt=%0d exp pc=23 cnt=2", bus.pc, bus.ras_count);
    end
    #2 rst = 1;
    #1;
    total++;
    if ({bus.pc, bus.flush, bus.ras_count, bus.err_ovf, bus.err_udf} !== 14'h0) begin
      bad++; $display("FAIL async_reset got=%h exp=0", {bus.pc, bus.flush, bus.ras_count, bus.err_ovf, bus.err_udf});
    end
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_seq_wrap();
    bit [7:0] exp_pc[3] = '{8'hFF, 8'h00, 8'h01};
    go(8'hFE);
    for (int i = 0; i < 3; i++) begin
      nop();
      total++;
      if (bus.pc !== exp_pc[i] || bus.flush !== 1'b0) begin
        bad++; $display("FAIL seq_wrap[%0d] got pc=%h flush=%b exp pc=%h flush=0", i, bus.pc, bus.flush, exp_pc[i]);
      end
    end
  endtask

  task automatic test_cond_jmp();
    go(8'h10);
    step(0, 1, 2'd1, 3'd1, 8'h40, 4'b0001);
    total++;
    if (bus.pc !== 8'h40 || bus.flush !== 1'b1) begin
      bad++; $display("FAIL jmp_taken got pc=%h flush=%b exp pc=40 flush=1", bus.pc, bus.flush);
    end
    nop();
    total++;
    if (bus.pc !== 8'h40 || bus.flush !== 1'b0) begin
      bad++; $display("FAIL jmp_bubble_end got pc=%h flush=%b exp pc=40 flush=0", bus.pc, bus.flush);
    end
    go(8'h10);
    step(0, 1, 2'd1, 3'd2, 8'h40, 4'b0001);
    total++;
    if (bus.pc !== 8'h11 || bus.flush !== 1'b0) begin
      bad++; $display("FAIL jmp_not_taken got pc=%h flush=%b exp pc=11 flush=0", bus.pc, bus.flush);
    end
  endtask

  task automatic test_call_ret();
    do_reset();
    go(8'h05);
    step(0, 1, 2'd2, 3'd0, 8'h80, 4'h0);
    total++;
    if (bus.pc !== 8'h80 || bus.flush !== 1'b1 || bus.ras_count !== 3'd1) begin
      bad++; $display("FAIL call got pc=%h flush=%b cnt=%0d exp pc=80 flush=1 cnt=1", bus.pc, bus.flush, bus.ras_count);
    end
    nop();
    total++;
    if (bus.pc !== 8'h80 || bus.flush !== 1'b0) begin
      bad++; $display("FAIL call_bubble got pc=%h flush=%b exp pc=80 flush=0", bus.pc, bus.flush);
    end
    nop();
    total++;
    if (bus.pc !== 8'h81) begin
      bad++; $display("FAIL call_seq got pc=%h exp pc=81", bus.pc);
    end
    step(0, 1, 2'd3, 3'd0, 8'h00, 4'h0);
    total++;
    if (bus.pc !== 8'h06 || bus.flush !== 1'b1 || bus.ras_count !== 3'd0) begin
      bad++; $display("FAIL ret got pc=%h flush=%b cnt=%0d exp pc=06 flush=1 cnt=0", bus.pc, bus.flush, bus.ras_count);
    end
    nop();
    total++;
    if (bus.flush !== 1'b0) begin
      bad++; $display("FAIL ret_bubble_end got flush=%b exp flush=0", bus.flush);
    end
  endtask

  task automatic test_stack_limits();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 2'd2, 3'd0, 8'((i + 1) * 16), 4'h0);
      total++;
      if (bus.ras_count !== 3'(i < 4 ? i + 1 : 4) || bus.err_ovf !== (i == 4)) begin
        bad++; $display("FAIL push[%0d] got cnt=%0d ovf=%b exp cnt=%0d ovf=%b", i, bus.ras_count, bus.err_ovf, (i < 4 ? i + 1 : 4), (i == 4));
      end
      nop();
    end
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 2'd3, 3'd0, 8'h00, 4'h0);
      total++;
      if (bus.pc !== 8'h31 - 8'(16 * i) || bus.flush !== 1'b1) begin
        bad++; $display("FAIL pop[%0d] got pc=%h flush=%b exp pc=%h flush=1", i, bus.pc, bus.flush, 8'h31 - 8'(16 * i));
      end
      nop();
    end
    step(0, 1, 2'd3, 3'd0, 8'h00, 4'h0);
    total++;
    if (bus.pc !== 8'h02 || bus.flush !== 1'b0 || bus.err_udf !== 1'b1 || bus.ras_count !== 3'd0) begin
      bad++; $display("FAIL underflow got pc=%h flush=%b udf=%b cnt=%0d exp pc=02 flush=0 udf=1 cnt=0", bus.pc, bus.flush, bus.err_udf, bus.ras_count);
    end
  endtask

  task automatic test_stall();
    do_reset();
    step(0, 1, 2'd1, 3'd0, 8'h30, 4'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2'd1, 3'd0, 8'h99, 4'h0);
      total++;
      if (bus.pc !== 8'h30 || bus.flush !== 1'b1) begin
        bad++; $display("FAIL stall_hold[%0d] got pc=%h flush=%b exp pc=30 flush=1", i, bus.pc, bus.flush);
      end
    end
    step(0, 1, 2'd1, 3'd0, 8'h99, 4'h0);
    total++;
    if (bus.pc !== 8'h30 || bus.flush !== 1'b0) begin
      bad++; $display("FAIL stall_release got pc=%h flush=%b exp pc=30 flush=0", bus.pc, bus.flush);
    end
    step(0, 1, 2'd1, 3'd0, 8'h99, 4'h0);
    total++;
    if (bus.pc !== 8'h99 || bus.flush !== 1'b1) begin
      bad++; $display("FAIL stall_next_op got pc=%h flush=%b exp pc=99 flush=1", bus.pc, bus.flush);
    end
    step(1, 0, 2'd0, 3'd0, 8'h00, 4'h0);
    #2 rst = 1;
    #1;
    total++;
    if (bus.pc !== 8'h00 || bus.flush !== 1'b0) begin
      bad++; $display("FAIL reset_in_stalled_bubble got pc=%h flush=%b exp pc=00 flush=0", bus.pc, bus.flush);
    end
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_random();
    bit [13:0] got, exp;
    for (int i = 0; i < 400; i++) begin
      if (i % 100 == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0, 2'($urandom), 3'($urandom),
           8'($urandom), 4'($urandom));
      got = {bus.pc, bus.flush, bus.ras_count, bus.err_ovf, bus.err_udf};
      exp = {mpc, mbub, 3'(mstack.size()), movf, mudf};
      total++;
      if (got !== exp) begin
        bad++; $display("FAIL random[%0d] got pc=%h fl=%b cnt=%0d ovf=%b udf=%b exp pc=%h fl=%b cnt=%0d ovf=%b udf=%b",
                        i, got[13:6], got[5], got[4:2], got[1], got[0], exp[13:6], exp[5], exp[4:2], exp[1], exp[0]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_seq_wrap();
    test_cond_jmp();
    test_call_ret();
    test_stack_limits();
    test_stall();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter and branch-resolution stage sitting directly downstream of the flag register in the tiny CPU. It consumes the registered ALU flags to resolve conditional jumps, handles CALL/RET through a small return-address stack, and issues a one-cycle flush bubble after every taken control transfer. Sequential fetch advances the PC by one per cycle unless stalled.

## Interface
- ADDR_W, 8, PC and target width
- RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high; clears all state immediately
- stall  in  1  freeze: no state change while high
- op_valid  in  1  op/cond/target valid this cycle
- op  in  2  00 NOP, 01 JMP, 10 CALL, 11 RET
- cond  in  3  JMP condition: 0 always, 1 Z, 2 !Z, 3 C, 4 !C, 5 V, 6 !V, 7 N
- target  in  ADDR_W  JMP/CALL destination
- stored_flags  in  4  registered flags: bit0 Z, bit1 V (overflow), bit2 C, bit3 N
- pc  out  ADDR_W  current program counter
- flush  out  1  high for the one cycle following a taken transfer
- ras_count  out  clog2(RAS_DEPTH+1)  stack occupancy
- err_ovf  out  1  sticky: CALL issued with stack full
- err_udf  out  1  sticky: RET issued with stack empty

## Operation
- States: RUN, BUBBLE.
- RUN, stall=0: evaluate op (op_valid=0 treated as NOP).
  - NOP: pc <= pc+1.
  - JMP: condition true -> pc <= target, go BUBBLE; false -> pc <= pc+1.
  - CALL: always taken; push pc+1, pc <= target, go BUBBLE. Stack full -> push dropped, err_ovf <= 1, ras_count unchanged, jump still taken.
  - RET: stack non-empty -> pop, pc <= popped value, go BUBBLE. Empty -> err_udf <= 1, pc <= pc+1, stay RUN, no flush.
- BUBBLE, stall=0: flush=1, op inputs ignored, pc held, return to RUN next edge.
- stall=1 in any state: pc, state, stack, errors held; flush output held at its current value (the bubble is extended, not lost).
- Condition evaluated combinationally from stored_flags present in the same cycle; a flag write on the same edge is not visible until the next cycle (compiler/sequencer must space the compare and the JMP by one instruction).
- Arithmetic: pc+1 wraps modulo 2^ADDR_W (all-ones -> 0); pushed return address wraps likewise.
- Stack is LIFO; ras_count ranges 0..RAS_DEPTH; no entries beyond RAS_DEPTH are retained.
- err_ovf/err_udf clear only on rst.

## Timing
- Reset values: pc=RESET_PC, state RUN, flush=0, ras_count=0, err_ovf=0, err_udf=0; stack contents don't-care.
- rst assertion mid-operation (including in BUBBLE or while stalled) clears immediately, without waiting for clk.
- First rising edge after rst deasserts performs a normal RUN evaluation.
- Taken transfer resolved at edge N: pc=target after N, flush=1 during cycle N..N+1, first op accepted at edge N+2.
- Not-taken JMP: zero penalty, pc+1 after the edge.
- flush is a registered output (state==BUBBLE), no combinational path from inputs.

## Test plan
- Reset: assert rst asynchronously mid-cycle with pc=0x23, ras_count=2 -> pc=0x00, ras_count=0, flush=0, errors 0 before next edge.
- Sequential + wrap: pc=0xFE, three NOP cycles -> pc 0xFF, 0x00, 0x01.
- Conditional JMP: stored_flags=4'b0001, JMP cond=1 target=0x40 at pc=0x10 -> pc=0x40, flush=1 one cycle; same with cond=2 -> pc=0x11, flush=0.
- CALL/RET: pc=0x05 CALL target=0x80, then NOP, then RET -> pc 0x80, (bubble) 0x80, 0x81, RET -> pc=0x06, ras_count 1 -> 0, flush after each transfer.
- Stack limits: five CALLs with RAS_DEPTH=4 -> ras_count=4, err_ovf=1; five RETs -> fifth sets err_udf=1, pc advances by 1, no flush.
- Stall: stall=1 during BUBBLE for 3 cycles with JMP presented -> pc, flush=1 held, JMP ignored; release -> RUN, next op accepted.
